// File: rtl/cve2_fp_wb_scoreboard_if.sv
// Decoder, writeback-stream and register-file signal bundle for the FP writeback scoreboard.
// The master side drives requests and operands; the slave side is the scoreboard.
interface cve2_fp_wb_scoreboard_if #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumRegs   = 32
);
   logic                 issue_valid_i;
   logic [4:0]           issue_rd_i;
   logic                 issue_ready_o;
   logic                 fpu_wb_valid_i;
   logic [4:0]           fpu_wb_rd_i;
   logic [DataWidth-1:0] fpu_wb_data_i;
   logic                 fpu_wb_ready_o;
   logic                 lsu_wb_valid_i;
   logic [4:0]           lsu_wb_rd_i;
   logic [DataWidth-1:0] lsu_wb_data_i;
   logic                 lsu_wb_ready_o;
   logic [4:0]           raddr_a_i;
   logic [4:0]           raddr_b_i;
   logic [4:0]           raddr_c_i;
   logic                 hazard_o;
   logic                 rf_we_o;
   logic [4:0]           rf_waddr_o;
   logic [DataWidth-1:0] rf_wdata_o;
   logic [NumRegs-1:0]   busy_o;
   logic                 wb_err_o;
   logic [31:0]          perf_conflict_o;

   modport master (
      output issue_valid_i, issue_rd_i,
      output fpu_wb_valid_i, fpu_wb_rd_i, fpu_wb_data_i,
      output lsu_wb_valid_i, lsu_wb_rd_i, lsu_wb_data_i,
      output raddr_a_i, raddr_b_i, raddr_c_i,
      input  issue_ready_o, fpu_wb_ready_o, lsu_wb_ready_o, hazard_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, wb_err_o, perf_conflict_o
   );

   modport slave (
      input  issue_valid_i, issue_rd_i,
      input  fpu_wb_valid_i, fpu_wb_rd_i, fpu_wb_data_i,
      input  lsu_wb_valid_i, lsu_wb_rd_i, lsu_wb_data_i,
      input  raddr_a_i, raddr_b_i, raddr_c_i,
      output issue_ready_o, fpu_wb_ready_o, lsu_wb_ready_o, hazard_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o, busy_o, wb_err_o, perf_conflict_o
   );
endinterface

// File: rtl/cve2_fp_wb_scoreboard.sv
// FP register-file write-port controller: destination scoreboard, round-robin FPU/LSU
// writeback arbitration and hazard detection. Optional conflict counter: CVE2_FP_WB_PERF_EN.
module cve2_fp_wb_scoreboard #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned NumRegs   = 32
) (
   input logic                    clk_i,
   input logic                    rst_ni,
   cve2_fp_wb_scoreboard_if.slave sb
);
   localparam int unsigned AW       = $clog2(NumRegs);
   localparam logic [4:0]  AddrMask = 5'(NumRegs - 1);

   logic [NumRegs-1:0]   busy_r;
   logic [NumRegs-1:0]   busy_d_s;
   logic [NumRegs-1:0]   busy_set_s;
   logic [NumRegs-1:0]   busy_clr_s;
   logic                 we_r;
   logic                 we_d_s;
   logic [4:0]           waddr_r;
   logic [4:0]           waddr_d_s;
   logic [DataWidth-1:0] wdata_r;
   logic [DataWidth-1:0] wdata_d_s;
   logic                 last_grant_r;
   logic                 last_grant_d_s;
   logic                 err_r;
   logic                 err_d_s;

   logic [AW-1:0]        issue_idx_s;
   logic [AW-1:0]        sel_idx_s;
   logic                 issue_ready_s;
   logic                 grant_fpu_s;
   logic                 grant_lsu_s;
   logic                 grant_s;
   logic                 sel_busy_s;
   logic [4:0]           sel_rd_s;
   logic [DataWidth-1:0] sel_data_s;

   assign issue_idx_s   = sb.issue_rd_i[AW-1:0];
   assign issue_ready_s = sb.issue_valid_i & ~busy_r[issue_idx_s];

   // Round-robin grant: on a tie the stream that did not win last time goes first.
   always_comb begin
      grant_fpu_s = 1'b0;
      grant_lsu_s = 1'b0;
      case ({sb.fpu_wb_valid_i, sb.lsu_wb_valid_i})
         2'b10: grant_fpu_s = 1'b1;
         2'b01: grant_lsu_s = 1'b1;
         2'b11: begin
            if (last_grant_r) begin
               grant_fpu_s = 1'b1;
            end else begin
               grant_lsu_s = 1'b1;
            end
         end
         default: begin
            grant_fpu_s = 1'b0;
            grant_lsu_s = 1'b0;
         end
      endcase
   end

   // Steer the winning stream's destination and data toward the write stage.
   always_comb begin
      grant_s = grant_fpu_s | grant_lsu_s;
      if (grant_lsu_s) begin
         sel_rd_s   = sb.lsu_wb_rd_i;
         sel_data_s = sb.lsu_wb_data_i;
      end else begin
         sel_rd_s   = sb.fpu_wb_rd_i;
         sel_data_s = sb.fpu_wb_data_i;
      end
      sel_idx_s  = sel_rd_s[AW-1:0];
      sel_busy_s = busy_r[sel_idx_s];
   end

   // Next scoreboard state: the write retiring this cycle frees its register,
   // a fresh reservation claims another one (never the same, issue is blocked while busy).
   always_comb begin
      busy_set_s = '0;
      busy_clr_s = '0;
      if (issue_ready_s) begin
         busy_set_s[issue_idx_s] = 1'b1;
      end else begin
         busy_set_s = '0;
      end
      if (we_r) begin
         busy_clr_s[waddr_r[AW-1:0]] = 1'b1;
      end else begin
         busy_clr_s = '0;
      end
      busy_d_s = (busy_r & ~busy_clr_s) | busy_set_s;
   end

   // Next write stage; a granted result to an unreserved register is dropped and flagged.
   always_comb begin
      we_d_s         = 1'b0;
      waddr_d_s      = waddr_r;
      wdata_d_s      = wdata_r;
      last_grant_d_s = last_grant_r;
      err_d_s        = err_r;
      if (grant_s) begin
         we_d_s         = sel_busy_s;
         waddr_d_s      = sel_rd_s & AddrMask;
         wdata_d_s      = sel_data_s;
         last_grant_d_s = grant_lsu_s;
         err_d_s        = err_r | ~sel_busy_s;
      end else begin
         we_d_s = 1'b0;
      end
   end

   // State registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         busy_r       <= '0;
         we_r         <= 1'b0;
         waddr_r      <= 5'd0;
         wdata_r      <= '0;
         last_grant_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         busy_r       <= busy_d_s;
         we_r         <= we_d_s;
         waddr_r      <= waddr_d_s;
         wdata_r      <= wdata_d_s;
         last_grant_r <= last_grant_d_s;
         err_r        <= err_d_s;
      end
   end

   assign sb.issue_ready_o  = issue_ready_s;
   assign sb.fpu_wb_ready_o = grant_fpu_s;
   assign sb.lsu_wb_ready_o = grant_lsu_s;
   assign sb.hazard_o       = busy_r[sb.raddr_a_i[AW-1:0]] |
                              busy_r[sb.raddr_b_i[AW-1:0]] |
                              busy_r[sb.raddr_c_i[AW-1:0]];
   assign sb.rf_we_o        = we_r;
   assign sb.rf_waddr_o     = waddr_r;
   assign sb.rf_wdata_o     = wdata_r;
   assign sb.busy_o         = busy_r;
   assign sb.wb_err_o       = err_r;

`ifdef CVE2_FP_WB_PERF_EN
   logic [31:0] perf_cnt_r;

   // Saturating count of cycles in which both writeback streams compete.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_cnt_r <= 32'd0;
      end else if (sb.fpu_wb_valid_i && sb.lsu_wb_valid_i && (perf_cnt_r != 32'hFFFF_FFFF)) begin
         perf_cnt_r <= perf_cnt_r + 32'd1;
      end else begin
         perf_cnt_r <= perf_cnt_r;
      end
   end

   assign sb.perf_conflict_o = perf_cnt_r;
`else
   assign sb.perf_conflict_o = 32'd0;
`endif

endmodule

// File: doc/cve2_fp_wb_scoreboard.md
Name: cve2_fp_wb_scoreboard

Overview:
- Write-port controller and hazard scoreboard for the core's flip-flop floating-point register file (3 read ports, 1 write port).
- Tracks destination registers reserved by in-flight FP instructions (FPU ops, FLW loads).
- Arbitrates the FPU and LSU writeback streams onto the single write port.
- Flags read-after-write and write-after-write hazards to the decoder.

Parameters:
- DataWidth, 32, width of writeback data and rf_wdata_o.
- NumRegs, 32, number of FP registers tracked (power of two, 16 or 32); address width AW = $clog2(NumRegs).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decoder requests a destination reservation
- issue_rd_i  in  5  destination register (upper bits ignored when AW<5)
- issue_ready_o  out  1  reservation accepted this cycle
- fpu_wb_valid_i  in  1  FPU result valid
- fpu_wb_rd_i  in  5  FPU result destination
- fpu_wb_data_i  in  DataWidth  FPU result
- fpu_wb_ready_o  out  1  FPU result granted
- lsu_wb_valid_i  in  1  load data valid
- lsu_wb_rd_i  in  5  load destination
- lsu_wb_data_i  in  DataWidth  load data
- lsu_wb_ready_o  out  1  load data granted
- raddr_a_i / raddr_b_i / raddr_c_i  in  5 each  source operands being decoded
- hazard_o  out  1  some source register is busy
- rf_we_o  out  1  register file write enable
- rf_waddr_o  out  5  register file write address
- rf_wdata_o  out  DataWidth  register file write data
- busy_o  out  NumRegs  scoreboard busy vector
- wb_err_o  out  1  sticky: writeback arrived to a non-busy register
- perf_conflict_o  out  32  arbitration conflict count (see Optional Feature)

Behaviour:
- State:
  - busy_q[NumRegs].
  - Registered write stage: we_q, waddr_q, wdata_q.
  - last_grant_q: 0 = FPU, 1 = LSU.
  - err_q.
- Reset values: all of the above 0, so rf_we_o = 0, rf_waddr_o = 0, rf_wdata_o = 0, busy_o = 0, wb_err_o = 0, perf_conflict_o = 0. Reset mid-operation drops any pending write.
- issue_ready_o = issue_valid_i & ~busy_q[issue_rd_i].
- On issue handshake, busy_q[rd] is set at the clock edge.
- A second reservation of a busy rd stalls (WAW), including in the cycle in which rd is being written back. The set becomes visible one cycle later.
- hazard_o is combinational: busy_q[raddr_a_i] | busy_q[raddr_b_i] | busy_q[raddr_c_i].
- Arbitration is round-robin between the writeback streams:
  - Only one valid: it is granted.
  - Both valid: grant the source not equal to last_grant_q.
  - last_grant_q updates only on a grant.
  - ready is combinational from the valids and last_grant_q. Valid may not depend on ready.
- Writeback timing:
  - Grant in cycle t: we_q, waddr_q, wdata_q are loaded, so rf_we_o = 1 in t+1.
  - The RF flop updates at the end of t+1.
  - busy_q[waddr_q] is cleared at the end of t+1, so a read decoded in t+2 sees no hazard and the new data.
  - No grant: we_q = 0; waddr_q and wdata_q hold their values.
- Writeback to a non-busy rd:
  - Still granted (stream not blocked).
  - Write suppressed (we_q = 0).
  - err_q set. Cleared only by reset.
- Same-cycle events:
  - An issue set and a writeback clear of different registers both take effect.
  - The same register cannot coincide, because issue is blocked while busy.
- Throughput: one write per cycle sustained, no bubbles.

Optional Feature:
- Macro: CVE2_FP_WB_PERF_EN.
- When defined:
  - A 32-bit counter increments every cycle in which fpu_wb_valid_i & lsu_wb_valid_i.
  - The counter saturates at 32'hFFFF_FFFF and resets to 0.
  - perf_conflict_o = counter.
- When undefined: no counter flops; perf_conflict_o tied to '0.

Test Plan:
- Reset, then idle → all outputs 0; issue rd=5 → issue_ready_o=1; next cycle busy_o[5]=1, and raddr_b_i=5 gives hazard_o=1.
- With busy[5] set, issue rd=5 again → issue_ready_o=0; FPU writes rd=5, data 32'h3F80_0000, granted at t → rf_we_o=1, rf_waddr_o=5, rf_wdata_o=32'h3F80_0000 at t+1; busy_o[5]=0 at t+2; the stalled issue is accepted at t+2.
- Reserve f1 and f2; FPU (rd=1) and LSU (rd=2) valid together for 2 cycles after reset → FPU wins the first cycle? No: last_grant=0 at reset, so LSU wins the first cycle and FPU the second. Writes to 2 then 1 on consecutive cycles; no bubble.
- LSU writeback to non-busy rd=7 → lsu_wb_ready_o=1, rf_we_o stays 0, wb_err_o=1 and remains 1.
- Assert rst_ni low in the cycle after a grant → rf_we_o=0 immediately, busy_o=0, wb_err_o=0.
- With CVE2_FP_WB_PERF_EN, both streams valid for 4 cycles → perf_conflict_o=4. Without the macro → perf_conflict_o stays 0.
